t03_imm_gen_pipe: RTL and testbench

Registered, parametrised immediate generator that sits between fetch and the decode/execute boundary. It accepts instructions over a valid/ready handshake and produces an XLEN-wide immediate plus a format code. Results are held in a small in-order output buffer so that fetch is decoupled from a stalling consumer. Compared with the combinational generator, it adds XLEN generalisation, shift-amount and CSR zimm formats, a flush input, and buffered backpressure.

---
 rtl/t03_imm_pkg.sv | 43 ++++
 rtl/t03_imm_gen_pipe_decode.sv | 83 ++++++++
 rtl/t03_imm_gen_pipe.sv | 117 +++++++++++
 tb/tb_t03_imm_gen_pipe.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/t03_imm_pkg.sv
// -----------------------------------------------------------------------------
// t03_imm_pkg
// Shared definitions for the pipelined immediate generator:
//   imm_fmt_t   - 3-bit format code carried with every buffered result
//   OP_*/...    - RV base opcodes the decoder recognises
//   imm_entry_t - canonical layout of one buffered result at the widest legal
//                 configuration (64-bit immediate, 64-bit tag); consumers that
//                 need a fixed-width record use this, the generator itself
//                 stores its fields at the configured widths
// -----------------------------------------------------------------------------
package t03_imm_pkg;

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6,
        FMT_ZIMM  = 3'd7
    } imm_fmt_t;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    localparam int IMM_MAXW = 64;
    localparam int TAG_MAXW = 64;

    typedef struct packed {
        logic [IMM_MAXW-1:0] imm;
        imm_fmt_t            fmt;
        logic [TAG_MAXW-1:0] tag;
    } imm_entry_t;

endpackage

// File: rtl/t03_imm_gen_pipe_decode.sv
// -----------------------------------------------------------------------------
// t03_imm_decode
// Combinational immediate decoder: instruction word -> XLEN-wide immediate and
// format code.
//   instr : input  [31:0]     RV instruction word
//   imm   : output [XLEN-1:0] extended immediate (0 for FMT_NONE)
//   fmt   : output imm_fmt_t  format code
// -----------------------------------------------------------------------------
module t03_imm_decode
    import t03_imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output imm_fmt_t        fmt
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [XLEN-1:0] shamt;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    // RV64 shifts carry a 6-bit shift amount; RV32 only 5 (bit 25 belongs to funct7).
    generate
        if (XLEN == 64) begin : g_shamt64
            assign shamt = XLEN'(instr[25:20]);
        end else begin : g_shamt32
            assign shamt = XLEN'(instr[24:20]);
        end
    endgenerate

    // Sized casts of $signed values replicate instr[31] up to XLEN.
    always_comb begin
        imm = '0;
        fmt = FMT_NONE;
        case (opcode)
            OP_IMM: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    imm = shamt;
                    fmt = FMT_SHAMT;
                end else begin
                    imm = XLEN'($signed(instr[31:20]));
                    fmt = FMT_I;
                end
            end
            LOAD, JALR: begin
                imm = XLEN'($signed(instr[31:20]));
                fmt = FMT_I;
            end
            STORE: begin
                imm = XLEN'($signed({instr[31:25], instr[11:7]}));
                fmt = FMT_S;
            end
            BRANCH: begin
                imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
                fmt = FMT_B;
            end
            JAL: begin
                imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
                fmt = FMT_J;
            end
            LUI, AUIPC: begin
                imm = XLEN'($signed({instr[31:12], 12'b0}));
                fmt = FMT_U;
            end
            SYSTEM: begin
                // Only the immediate CSR forms (funct3[2]=1) carry a zimm.
                if (funct3[2]) begin
                    imm = XLEN'(instr[19:15]);
                    fmt = FMT_ZIMM;
                end
            end
            default: begin
                imm = '0;
                fmt = FMT_NONE;
            end
        endcase
    end

endmodule

// File: rtl/t03_imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// t03_imm_gen_pipe
// Registered immediate generator with an in-order output buffer between fetch
// and decode/execute.
//   clk       : input             system clock, rising edge
//   nrst      : input             asynchronous active-low reset
//   flush     : input             synchronous; discards all buffered entries
//   in_valid  : input             instruction present
//   in_ready  : output            buffer can accept (count < DEPTH)
//   in_instr  : input  [31:0]     instruction word
//   in_tag    : input  [TAGW-1:0] sideband tag (normally PC)
//   out_valid : output            head entry valid (count != 0)
//   out_ready : input             consumer takes head entry
//   out_imm   : output [XLEN-1:0] head immediate
//   out_fmt   : output [2:0]      head format code
//   out_tag   : output [TAGW-1:0] head tag
//
// Handshake: a transfer happens on a rising edge where valid && ready on that
// side. in_ready depends only on the stored count, so a full buffer never
// passes an instruction through on a same-cycle pop. Outputs come straight
// from the head register, never from the input.
// -----------------------------------------------------------------------------
module t03_imm_gen_pipe
    import t03_imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int TAGW  = 32
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [TAGW-1:0] out_tag
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [XLEN-1:0] imm_q [DEPTH];
    imm_fmt_t        fmt_q [DEPTH];
    logic [TAGW-1:0] tag_q [DEPTH];

    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic [XLEN-1:0] dec_imm;
    imm_fmt_t        dec_fmt;
    logic            push;
    logic            pop;

    t03_imm_decode #(
        .XLEN(XLEN)
    ) u_decode (
        .instr(in_instr),
        .imm  (dec_imm),
        .fmt  (dec_fmt)
    );

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign in_ready  = (count < FULL_CNT);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Storage is cleared on reset so the head outputs read zero immediately.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                imm_q[i] <= '0;
                fmt_q[i] <= FMT_NONE;
                tag_q[i] <= '0;
            end
        end else if (flush) begin
            // Flush wins over any same-cycle push or pop.
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                imm_q[wr_ptr] <= dec_imm;
                fmt_q[wr_ptr] <= dec_fmt;
                tag_q[wr_ptr] <= in_tag;
                wr_ptr        <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign out_imm = imm_q[rd_ptr];
    assign out_fmt = fmt_q[rd_ptr];
    assign out_tag = tag_q[rd_ptr];

endmodule

// File: tb/tb_t03_imm_gen_pipe.sv
module tb_t03_imm_gen_pipe;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  fmt;
    string       name;
  } vec_t;

  localparam logic [2:0] F_NONE = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3,
                         F_U = 3'd4, F_J = 3'd5, F_SH = 3'd6, F_Z = 3'd7;

  logic        clk;
  logic        nrst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_tag;
  logic        out_ready;

  logic        in_ready32, out_valid32, in_ready64, out_valid64;
  logic [31:0] out_imm32;
  logic [63:0] out_imm64;
  logic [2:0]  out_fmt32, out_fmt64;
  logic [31:0] out_tag32, out_tag64;

  int tests_run;
  int tests_failed;

  vec_t vecs[14];

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  t03_imm_gen_pipe #(.XLEN(32), .DEPTH(2), .TAGW(32)) dut32 (
    .clk(clk), .nrst(nrst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(out_imm32), .out_fmt(out_fmt32), .out_tag(out_tag32)
  );

  t03_imm_gen_pipe #(.XLEN(64), .DEPTH(2), .TAGW(32)) dut64 (
    .clk(clk), .nrst(nrst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_fmt(out_fmt64), .out_tag(out_tag64)
  );

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string name);
    check({name, " out_valid32"}, 64'(out_valid32), 64'd0);
    check({name, " out_valid64"}, 64'(out_valid64), 64'd0);
    check({name, " in_ready32"}, 64'(in_ready32), 64'd1);
    check({name, " in_ready64"}, 64'(in_ready64), 64'd1);
  endtask

  task automatic check_head(input string name, input logic [31:0] tag);
    check({name, " out_valid32"}, 64'(out_valid32), 64'd1);
    check({name, " out_valid64"}, 64'(out_valid64), 64'd1);
    check({name, " out_tag32"}, 64'(out_tag32), 64'(tag));
    check({name, " out_tag64"}, 64'(out_tag64), 64'(tag));
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] tag);
    in_valid = v;
    in_instr = instr;
    in_tag   = tag;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, F_I,    "addi -1"};
    vecs[1]  = '{32'hFE000EE3, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, F_B,    "beq -4"};
    vecs[2]  = '{32'h01F09093, 32'h0000001F, 64'h000000000000001F, F_SH,   "slli 31"};
    vecs[3]  = '{32'h3002D073, 32'h00000005, 64'h0000000000000005, F_Z,    "csrrwi 5"};
    vecs[4]  = '{32'h800000B7, 32'h80000000, 64'hFFFFFFFF80000000, F_U,    "lui 0x80000"};
    vecs[5]  = '{32'h123450B7, 32'h12345000, 64'h0000000012345000, F_U,    "lui 0x12345"};
    vecs[6]  = '{32'hFE552C23, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, F_S,    "sw -8"};
    vecs[7]  = '{32'h001000EF, 32'h00000800, 64'h0000000000000800, F_J,    "jal 2048"};
    vecs[8]  = '{32'hFFDFF06F, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, F_J,    "jal -4"};
    vecs[9]  = '{32'h003100B3, 32'h00000000, 64'h0000000000000000, F_NONE, "add"};
    vecs[10] = '{32'h7FF12083, 32'h000007FF, 64'h00000000000007FF, F_I,    "lw 2047"};
    vecs[11] = '{32'h00008067, 32'h00000000, 64'h0000000000000000, F_I,    "jalr 0"};
    vecs[12] = '{32'h4210D093, 32'h00000001, 64'h0000000000000021, F_SH,   "srai 33"};
    vecs[13] = '{32'hFFFFF097, 32'hFFFFF000, 64'hFFFFFFFFFFFFF000, F_U,    "auipc -1"};

    nrst = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);

    // ---------------- reset values ----------------
    #2;
    check_idle("reset");
    check("reset out_imm32", 64'(out_imm32), 64'd0);
    check("reset out_imm64", out_imm64, 64'd0);
    check("reset out_fmt32", 64'(out_fmt32), 64'(F_NONE));
    check("reset out_tag32", 64'(out_tag32), 64'd0);
    @(negedge clk);
    nrst = 1'b1;

    // ---------------- table-driven decode, streamed back-to-back ----------------
    @(negedge clk);
    drive(1'b1, vecs[0].instr, 32'h100);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      check_head(vecs[i].name, 32'h100 + 32'(i));
      check({vecs[i].name, " imm32"}, 64'(out_imm32), 64'(vecs[i].imm32));
      check({vecs[i].name, " imm64"}, out_imm64, vecs[i].imm64);
      check({vecs[i].name, " fmt32"}, 64'(out_fmt32), 64'(vecs[i].fmt));
      check({vecs[i].name, " fmt64"}, 64'(out_fmt64), 64'(vecs[i].fmt));
      if (i < 13) drive(1'b1, vecs[i + 1].instr, 32'h100 + 32'(i + 1));
      else drive(1'b0, 32'h0, 32'h0);
    end
    @(negedge clk);
    check_idle("drain");

    // ---------------- backpressure, DEPTH=2 ----------------
    out_ready = 1'b0;
    drive(1'b1, 32'hFFF00093, 32'd1);
    @(negedge clk);
    check("bp in_ready after 1", 64'(in_ready32), 64'd1);
    check_head("bp head1a", 32'd1);
    drive(1'b1, 32'hFFF00093, 32'd2);
    @(negedge clk);
    check("bp in_ready full", 64'(in_ready32), 64'd0);
    check("bp in_ready64 full", 64'(in_ready64), 64'd0);
    check_head("bp head1b", 32'd1);
    drive(1'b1, 32'h123450B7, 32'd3);
    @(negedge clk);
    check("bp in_ready held", 64'(in_ready32), 64'd0);
    check_head("bp head1c", 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    check_head("bp head2", 32'd2);
    check("bp in_ready after pop", 64'(in_ready32), 64'd1);
    @(negedge clk);
    check_head("bp head3", 32'd3);
    check("bp tag3 imm64", out_imm64, 64'h0000000012345000);
    drive(1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check_idle("bp empty");

    // ---------------- flush with full buffer ----------------
    out_ready = 1'b0;
    drive(1'b1, 32'hFFF00093, 32'd10);
    @(negedge clk);
    drive(1'b1, 32'hFFF00093, 32'd11);
    @(negedge clk);
    check("fl full", 64'(in_ready32), 64'd0);
    flush = 1'b1; out_ready = 1'b1;
    drive(1'b1, 32'h800000B7, 32'd12);
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check_idle("fl full after");

    // ---------------- flush overriding a real push ----------------
    out_ready = 1'b0;
    drive(1'b1, 32'hFE000EE3, 32'd13);
    @(negedge clk);
    check_head("fl one", 32'd13);
    flush = 1'b1;
    drive(1'b1, 32'h800000B7, 32'd14);
    @(negedge clk);
    flush = 1'b0;
    check_idle("fl push dropped");
    drive(1'b1, 32'h3002D073, 32'd15);
    @(negedge clk);
    check_head("fl next", 32'd15);
    check("fl next imm32", 64'(out_imm32), 64'd5);
    drive(1'b0, 32'h0, 32'h0);
    out_ready = 1'b1;
    @(negedge clk);
    check_idle("fl tag14 never");

    // ---------------- asynchronous reset mid-stream ----------------
    out_ready = 1'b0;
    drive(1'b1, 32'h800000B7, 32'd20);
    @(negedge clk);
    drive(1'b1, 32'hFFF00093, 32'd21);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0);
    check_head("rst before", 32'd20);
    #2;
    nrst = 1'b0;
    #1;
    check_idle("rst async");
    check("rst out_imm32", 64'(out_imm32), 64'd0);
    check("rst out_imm64", out_imm64, 64'd0);
    check("rst out_fmt64", 64'(out_fmt64), 64'(F_NONE));
    check("rst out_tag64", 64'(out_tag64), 64'd0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;
    drive(1'b1, 32'h7FF12083, 32'd22);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0);
    check_head("rst first push", 32'd22);
    check("rst first imm64", out_imm64, 64'h7FF);
    check("rst first fmt32", 64'(out_fmt32), 64'(F_I));
    @(negedge clk);
    check_idle("rst end");

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
